// File: rtl/noc_vc_arb_fifo.sv
// rtl/noc_vc_arb_fifo.sv - per-VC flit FIFOs feeding a round-robin, packet-locking output arbiter
module noc_vc_arb_fifo #(
  parameter int CHANNELS    = 2,
  parameter int DEPTH       = 8,
  parameter int THRESHOLD   = DEPTH - 2,
  parameter int FLIT_WIDTH  = 64,
  parameter int PACKET_LOCK = 1
) (
  input  logic                  noc_clk,
  input  logic                  noc_rst_n,
  input  logic                  i_clear,
  input  logic [CHANNELS-1:0]   i_valid,
  input  logic [FLIT_WIDTH-1:0] i_flit,
  input  logic                  i_tail,
  output logic [CHANNELS-1:0]   o_ready,
  output logic [CHANNELS-1:0]   o_vc_ready,
  output logic                  o_valid,
  output logic [CHANNELS-1:0]   o_vc,
  output logic [FLIT_WIDTH-1:0] o_flit,
  output logic                  o_tail,
  input  logic                  i_ready,
  output logic                  o_protocol_err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int VW = $clog2(CHANNELS);
  localparam logic [CHANNELS-1:0] VC_ONE = CHANNELS'(1);

  logic [FLIT_WIDTH:0] mem_q [CHANNELS][DEPTH];
  logic [PW-1:0] wr_ptr_q [CHANNELS];
  logic [PW-1:0] wr_ptr_d [CHANNELS];
  logic [PW-1:0] rd_ptr_q [CHANNELS];
  logic [PW-1:0] rd_ptr_d [CHANNELS];
  logic [CW-1:0] count_q  [CHANNELS];
  logic [CW-1:0] count_d  [CHANNELS];
  logic [VW-1:0] prio_q, prio_d, lock_vc_q, lock_vc_d, hold_vc_q, hold_vc_d;
  logic          lock_q, lock_d, hold_q, hold_d, err_q, err_d;

  logic                multi_hot, rr_found, xfer;
  logic [CHANNELS-1:0] push, pop, nonempty;
  logic [VW-1:0]       rr_vc, sel_vc, next_vc;

  always_comb begin
    int idx;
    idx = 0;
    multi_hot = |(i_valid & (i_valid - VC_ONE));
    for (int c = 0; c < CHANNELS; c++) begin
      nonempty[c]   = (count_q[c] != '0);
      o_ready[c]    = (count_q[c] != CW'(DEPTH));
      o_vc_ready[c] = (count_q[c] < CW'(THRESHOLD));
    end
    rr_found = 1'b0;
    rr_vc    = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = int'(prio_q) + k;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!rr_found && nonempty[idx]) begin
        rr_found = 1'b1;
        rr_vc    = VW'(idx);
      end
    end
    // A stalled offer is frozen; otherwise a held packet lock beats round-robin.
    if (hold_q)      sel_vc = hold_vc_q;
    else if (lock_q) sel_vc = lock_vc_q;
    else             sel_vc = rr_vc;
    o_valid          = nonempty[sel_vc];
    o_vc             = o_valid ? (VC_ONE << sel_vc) : '0;
    {o_tail, o_flit} = mem_q[sel_vc][rd_ptr_q[sel_vc]];
    xfer             = o_valid & i_ready;
    next_vc          = (sel_vc == VW'(CHANNELS - 1)) ? '0 : sel_vc + VW'(1);
  end

  always_comb begin
    prio_d    = prio_q;
    lock_d    = lock_q;
    lock_vc_d = lock_vc_q;
    hold_d    = o_valid & ~i_ready;
    hold_vc_d = sel_vc;
    err_d     = err_q | multi_hot;
    for (int c = 0; c < CHANNELS; c++) begin
      push[c]     = i_valid[c] & o_ready[c] & ~multi_hot & ~i_clear;
      pop[c]      = xfer & (sel_vc == VW'(c)) & ~i_clear;
      wr_ptr_d[c] = wr_ptr_q[c] + PW'(push[c]);
      rd_ptr_d[c] = rd_ptr_q[c] + PW'(pop[c]);
      count_d[c]  = count_q[c] + CW'(push[c]) - CW'(pop[c]);
    end
    if (xfer) begin
      if (PACKET_LOCK != 0) begin
        lock_d    = ~o_tail;
        lock_vc_d = sel_vc;
        if (o_tail) prio_d = next_vc;
      end else begin
        prio_d = next_vc;
      end
    end
    if (i_clear) begin
      prio_d    = '0;
      lock_d    = 1'b0;
      lock_vc_d = '0;
      hold_d    = 1'b0;
      err_d     = 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        wr_ptr_d[c] = '0;
        rd_ptr_d[c] = '0;
        count_d[c]  = '0;
      end
    end
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        count_q[c]  <= '0;
      end
      prio_q    <= '0;
      lock_q    <= 1'b0;
      lock_vc_q <= '0;
      hold_q    <= 1'b0;
      hold_vc_q <= '0;
      err_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      prio_q    <= prio_d;
      lock_q    <= lock_d;
      lock_vc_q <= lock_vc_d;
      hold_q    <= hold_d;
      hold_vc_q <= hold_vc_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge noc_clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (push[c]) mem_q[c][wr_ptr_q[c]] <= {i_tail, i_flit};
    end
  end

  assign o_protocol_err = err_q;

endmodule

// File: tb/tb_noc_vc_arb_fifo.sv
// tb/tb_noc_vc_arb_fifo.sv - table vectors plus scoreboarded sequences for noc_vc_arb_fifo
module tb_noc_vc_arb_fifo;
  localparam int DEPTH = 8;
  localparam int FW    = 16;

  logic          noc_clk = 1'b0;
  logic          noc_rst_n = 1'b0;
  logic          i_clear = 1'b0;
  logic [1:0]    i_valid = '0;
  logic [FW-1:0] i_flit = '0;
  logic          i_tail = 1'b0;
  logic          i_ready = 1'b0;

  logic [1:0]    o_ready_l, o_vc_ready_l, o_vc_l, o_ready_n, o_vc_ready_n, o_vc_n;
  logic          o_valid_l, o_tail_l, o_err_l, o_valid_n, o_tail_n, o_err_n;
  logic [FW-1:0] o_flit_l, o_flit_n;

  noc_vc_arb_fifo #(.CHANNELS(2), .DEPTH(DEPTH), .THRESHOLD(6), .FLIT_WIDTH(FW), .PACKET_LOCK(1)) u_lock (
    .noc_clk(noc_clk), .noc_rst_n(noc_rst_n), .i_clear(i_clear), .i_valid(i_valid),
    .i_flit(i_flit), .i_tail(i_tail), .o_ready(o_ready_l), .o_vc_ready(o_vc_ready_l),
    .o_valid(o_valid_l), .o_vc(o_vc_l), .o_flit(o_flit_l), .o_tail(o_tail_l),
    .i_ready(i_ready), .o_protocol_err(o_err_l));

  noc_vc_arb_fifo #(.CHANNELS(2), .DEPTH(DEPTH), .THRESHOLD(6), .FLIT_WIDTH(FW), .PACKET_LOCK(0)) u_nolock (
    .noc_clk(noc_clk), .noc_rst_n(noc_rst_n), .i_clear(i_clear), .i_valid(i_valid),
    .i_flit(i_flit), .i_tail(i_tail), .o_ready(o_ready_n), .o_vc_ready(o_vc_ready_n),
    .o_valid(o_valid_n), .o_vc(o_vc_n), .o_flit(o_flit_n), .o_tail(o_tail_n),
    .i_ready(i_ready), .o_protocol_err(o_err_n));

  always #5 noc_clk = ~noc_clk;

  typedef struct {
    logic [1:0]    valid;
    logic          tail;
    logic [FW-1:0] flit;
    logic          rdy;
    logic [1:0]    e_ready;
    logic [1:0]    e_vcr;
    logic          e_valid;
    logic [1:0]    e_vc;
  } vec_t;

  vec_t         tv [15];
  int           nvec = 0;
  int           nerr = 0;
  int           mcnt [2];
  logic [16:0]  sbq [2][$];
  logic [16:0]  log_l [$];
  logic [16:0]  log_n [$];
  logic [16:0]  exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge noc_clk);
    #1;
  endtask

  task automatic sb_reset();
    sbq[0].delete(); sbq[1].delete();
    mcnt[0] = 0; mcnt[1] = 0;
  endtask

  task automatic push(input int c, input logic [FW-1:0] f, input logic t);
    i_valid = 2'(1 << c);
    i_flit  = f;
    i_tail  = t;
    if (mcnt[c] < DEPTH) begin
      sbq[c].push_back({t, f});
      mcnt[c]++;
    end
    cycle();
    i_valid = '0;
  endtask

  task automatic do_clear();
    i_clear = 1'b1;
    cycle();
    i_clear = 1'b0;
    sb_reset();
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    i_ready = 1'b1;
    while ((o_valid_l || o_valid_n) && n < max_cyc) begin
      cycle();
      n++;
    end
    chk("drain_done", {o_valid_l, o_valid_n}, 2'b00);
    chk("sb_empty", sbq[0].size() + sbq[1].size(), 0);
  endtask

  task automatic chk_log(input string name, input logic [16:0] got [$], input logic [16:0] want [$]);
    chk({name, "_len"}, got.size(), want.size());
    for (int i = 0; i < want.size() && i < got.size(); i++)
      chk($sformatf("%s_%0d", name, i), got[i], want[i]);
  endtask

  // Transfers are judged half a cycle before the edge that performs them.
  always @(negedge noc_clk) begin
    int vi;
    if (noc_rst_n && !i_clear) begin
      if (o_valid_l && i_ready) begin
        vi = (o_vc_l == 2'b10) ? 1 : 0;
        chk("mon_vc_onehot", {31'd0, $onehot(o_vc_l)}, 1);
        log_l.push_back({vi[0], o_flit_l});
        chk("sb_has_entry", sbq[vi].size() != 0, 1);
        if (sbq[vi].size() != 0) chk("sb_flit", {o_tail_l, o_flit_l}, sbq[vi].pop_front());
        mcnt[vi]--;
      end
      if (!o_valid_l) chk("idle_vc_zero", o_vc_l, 0);
      if (o_valid_n && i_ready) log_n.push_back({o_vc_n == 2'b10, o_flit_n});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tv[0] = '{2'b00, 1'b0, 16'h0, 1'b0, 2'b11, 2'b11, 1'b0, 2'b00};
    for (int k = 1; k <= 8; k++)
      tv[k] = '{2'b01, 1'b1, 16'(16'h100 + k), 1'b0, (k == 8) ? 2'b10 : 2'b11,
                (k < 6) ? 2'b11 : 2'b10, 1'b1, 2'b01};
    tv[9]  = '{2'b01, 1'b1, 16'h1FF, 1'b0, 2'b10, 2'b10, 1'b1, 2'b01};
    tv[10] = '{2'b10, 1'b1, 16'h200, 1'b0, 2'b10, 2'b10, 1'b1, 2'b01};
    tv[11] = '{2'b00, 1'b0, 16'h0,   1'b1, 2'b11, 2'b10, 1'b1, 2'b10};
    tv[12] = '{2'b00, 1'b0, 16'h0,   1'b1, 2'b11, 2'b10, 1'b1, 2'b01};
    tv[13] = '{2'b00, 1'b0, 16'h0,   1'b1, 2'b11, 2'b10, 1'b1, 2'b01};
    tv[14] = '{2'b00, 1'b0, 16'h0,   1'b1, 2'b11, 2'b11, 1'b1, 2'b01};
    sb_reset();

    cycle(); cycle();
    noc_rst_n = 1'b1;

    // Fill VC0 to full, overflow it, then start draining.
    for (int i = 0; i < 15; i++) begin
      i_valid = tv[i].valid;
      i_tail  = tv[i].tail;
      i_flit  = tv[i].flit;
      i_ready = tv[i].rdy;
      if (tv[i].valid != 2'b00 && $onehot(tv[i].valid)) begin
        if (mcnt[tv[i].valid[1]] < DEPTH) begin
          sbq[tv[i].valid[1]].push_back({tv[i].tail, tv[i].flit});
          mcnt[tv[i].valid[1]]++;
        end
      end
      cycle();
      chk($sformatf("v%0d_ready", i), o_ready_l, tv[i].e_ready);
      chk($sformatf("v%0d_vc_ready", i), o_vc_ready_l, tv[i].e_vcr);
      chk($sformatf("v%0d_valid", i), o_valid_l, tv[i].e_valid);
      chk($sformatf("v%0d_vc", i), o_vc_l, tv[i].e_vc);
      chk($sformatf("v%0d_err", i), o_err_l, 0);
    end
    i_valid = '0;
    drain(40);
    chk("fill_ready_after", o_ready_l, 2'b11);

    // Packet lock vs per-flit arbitration on identical traffic.
    i_ready = 1'b0;
    do_clear();
    log_l.delete(); log_n.delete();
    push(0, 16'h300, 1'b0); push(0, 16'h301, 1'b0); push(0, 16'h302, 1'b1);
    push(1, 16'h400, 1'b1);
    chk("stall_vc", o_vc_l, 2'b01);
    chk("stall_flit", o_flit_l, 16'h300);
    drain(20);
    exp_q = '{{1'b0, 16'h300}, {1'b0, 16'h301}, {1'b0, 16'h302}, {1'b1, 16'h400}};
    chk_log("lock_order", log_l, exp_q);
    exp_q = '{{1'b0, 16'h300}, {1'b1, 16'h400}, {1'b0, 16'h301}, {1'b0, 16'h302}};
    chk_log("rr_order", log_n, exp_q);

    // Lock held on an empty VC1 starves a non-empty VC0.
    do_clear();
    log_l.delete();
    i_ready = 1'b1;
    push(1, 16'h500, 1'b0);
    push(0, 16'h600, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("starve_valid_%0d", i), o_valid_l, 0);
      cycle();
    end
    push(1, 16'h501, 1'b1);
    chk("unlock_valid", o_valid_l, 1);
    chk("unlock_vc", o_vc_l, 2'b10);
    drain(20);
    exp_q = '{{1'b1, 16'h500}, {1'b1, 16'h501}, {1'b0, 16'h600}};
    chk_log("starve_order", log_l, exp_q);

    // Multi-hot write strobe, then clear racing a push.
    do_clear();
    i_ready = 1'b0;
    i_valid = 2'b11;
    i_flit  = 16'h7AA;
    chk("err_before_edge", o_err_l, 0);
    cycle();
    i_valid = '0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("err_sticky_%0d", i), {o_err_l, o_err_n}, 2'b11);
      chk($sformatf("err_no_push_%0d", i), {o_valid_l, o_valid_n, o_ready_l}, 4'b0011);
      cycle();
    end
    i_valid = 2'b01;
    i_clear = 1'b1;
    cycle();
    i_valid = '0;
    i_clear = 1'b0;
    chk("clear_err", {o_err_l, o_err_n}, 2'b00);
    chk("clear_beats_push", {o_valid_l, o_valid_n}, 2'b00);

    // Asynchronous reset in the middle of a stalled packet.
    push(0, 16'h700, 1'b0); push(0, 16'h701, 1'b0); push(0, 16'h702, 1'b1);
    i_ready = 1'b1;
    cycle();
    i_ready = 1'b0;
    cycle();
    chk("pre_rst_valid", o_valid_l, 1);
    chk("pre_rst_flit", o_flit_l, 16'h701);
    #3 noc_rst_n = 1'b0;
    #1;
    chk("rst_valid_now", {o_valid_l, o_valid_n}, 2'b00);
    chk("rst_vc_now", {o_vc_l, o_vc_n}, 4'b0000);
    cycle(); cycle();
    noc_rst_n = 1'b1;
    sb_reset();
    cycle();
    chk("post_rst_valid", {o_valid_l, o_valid_n, o_vc_l, o_vc_n}, 6'b0);
    chk("post_rst_ready", {o_ready_l, o_ready_n}, 4'b1111);
    chk("post_rst_vc_ready", {o_vc_ready_l, o_vc_ready_n}, 4'b1111);
    chk("post_rst_err", {o_err_l, o_err_n}, 2'b00);
    push(1, 16'h800, 1'b1);
    drain(20);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/noc_vc_arb_fifo.md
NOC_VC_ARB_FIFO -- requirements
Module: noc_vc_arb_fifo

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, number of virtual channels (VCs), at least 2.
REQ-002 SHALL have parameter DEPTH, default 8, entries per VC, a power of 2, at least 2.
REQ-003 SHALL have parameter THRESHOLD, default DEPTH-2, per-VC occupancy at or above which that VC reports almost-full, in the range 1..DEPTH.
REQ-004 SHALL have parameter FLIT_WIDTH, default 64, flit payload width in bits.
REQ-005 SHALL have parameter PACKET_LOCK, default 1; 1 = hold the grant for a whole packet, 0 = re-arbitrate on every flit.
REQ-006 SHALL have ports, in this order:
- noc_clk  in  1  single clock; all logic rises on it.
- noc_rst_n  in  1  reset, asynchronous, active-low.
- i_clear  in  1  synchronous flush.
- i_valid  in  CHANNELS  one-hot write strobe per VC.
- i_flit  in  FLIT_WIDTH  write payload, shared by all VCs.
- i_tail  in  1  marks the written flit as the last of its packet.
- o_ready  out  CHANNELS  per VC, not full.
- o_vc_ready  out  CHANNELS  per VC, occupancy below THRESHOLD.
- o_valid  out  1  output flit available.
- o_vc  out  CHANNELS  one-hot VC of the output flit.
- o_flit  out  FLIT_WIDTH  output payload.
- o_tail  out  1  tail bit of the output flit.
- i_ready  in  1  downstream accepts the output flit.
- o_protocol_err  out  1  sticky flag: a multi-hot i_valid was seen.

Function
REQ-007 SHALL keep an independent circular buffer per VC: DEPTH entries of {tail, flit}, a write pointer, a read pointer, and a count of width $clog2(DEPTH+1); pointers wrap from DEPTH-1 to 0.
REQ-008 SHALL push to VC c when i_valid[c] & o_ready[c] and i_valid is one-hot.
REQ-009 SHALL ignore pushes to a full VC: no state change, no error.
REQ-010 SHALL, when i_valid has more than one bit set, push nothing and set o_protocol_err; the flag stays set until reset or i_clear.
REQ-011 SHALL drive o_ready[c] = (count[c] != DEPTH) and o_vc_ready[c] = (count[c] < THRESHOLD), both from registered state with no same-cycle pop bypass.
REQ-012 SHALL make a flit pushed in cycle N eligible for output no earlier than cycle N+1 (one-cycle latency, no bypass from input to output).
REQ-013 SHALL define a transfer as o_valid & i_ready; a transfer pops one entry from the VC selected by o_vc.
REQ-014 SHALL, when o_valid=1 and i_ready=0, hold o_vc, o_flit and o_tail stable; no re-arbitration while stalled.
REQ-015 SHALL arbitrate round-robin among non-empty VCs when no grant is held: search from the priority pointer upward, wrapping CHANNELS-1 to 0.
REQ-016 SHALL, with PACKET_LOCK=1, lock the grant to VC c after a non-tail transfer from c, and release the lock on the transfer of c's tail flit.
REQ-017 SHALL, while locked to c and c is empty, drive o_valid=0 and serve no other VC.
REQ-018 SHALL move the priority pointer to (granted VC + 1) mod CHANNELS on each tail transfer (PACKET_LOCK=1) or on each transfer (PACKET_LOCK=0).
REQ-019 SHALL allow a simultaneous push to VC a and pop from VC b, including a = b; when a = b the count is unchanged.
REQ-020 SHALL, on i_clear=1, empty all VCs, release the lock, reset the priority pointer to 0 and clear o_protocol_err; i_clear overrides any push or pop in the same cycle.
REQ-021 SHALL drive o_vc to 0 whenever o_valid=0.

Reset
REQ-022 SHALL, on noc_rst_n=0 (asynchronous), set all counts and pointers to 0, release the lock and set the priority pointer to 0.
REQ-023 SHALL, in and after reset until the first push, drive o_valid=0, o_vc=0, o_protocol_err=0, o_ready=all 1, and o_vc_ready=all 1 (THRESHOLD is at least 1).
REQ-024 SHALL require no memory-array reset; o_flit and o_tail are don't-care while o_valid=0.

Verification
REQ-025 SHALL cover: fill VC0 with 8 flits (DEPTH=8, THRESHOLD=6), i_ready=0 -> o_vc_ready[0] falls after the 6th push, o_ready[0] falls after the 8th; a 9th push is ignored.
REQ-026 SHALL cover: VC0 holds packet H,B,T and VC1 holds single-flit packet T, i_ready=1, PACKET_LOCK=1 -> output order VC0 H,B,T then VC1 T, no interleaving.
REQ-027 SHALL cover: same traffic with PACKET_LOCK=0 -> output order VC0, VC1, VC0, VC0.
REQ-028 SHALL cover: lock held on VC1, VC1 empty, VC0 non-empty -> o_valid=0 until VC1 receives a flit.
REQ-029 SHALL cover: i_valid=2'b11 -> no push on either VC, o_protocol_err=1 from the next cycle until i_clear.
REQ-030 SHALL cover: noc_rst_n asserted mid-packet with a stalled output -> o_valid=0 immediately, and all outputs match REQ-023 after release.
